// File: rtl/slm_bank_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// slm_bank_access_ctrl_if
//   Bundles the request/response handshakes and the two-port memory bank
//   signals of slm_bank_access_ctrl.
//
//   Request side : wr_valid/wr_ready/wr_addr/wr_data/wr_mask,
//                  rd_valid/rd_ready/rd_addr
//   Response side: rsp_valid/rsp_ready/rsp_data
//   Memory side  : CE0/A0/D0/WE0/WEM0 (write port), CE1/A1/Q1 (read port,
//                  Q1 valid one cycle after CE1)
//
//   Modports:
//     slave  - the controller's view (drives ready/response/memory controls)
//     master - the environment's view (requesters, consumer and memory)
// ----------------------------------------------------------------------------
interface slm_bank_access_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 64
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_mask;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    logic              CE0;
    logic [ADDR_W-1:0] A0;
    logic [DATA_W-1:0] D0;
    logic              WE0;
    logic [DATA_W-1:0] WEM0;
    logic              CE1;
    logic [ADDR_W-1:0] A1;
    logic [DATA_W-1:0] Q1;

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_mask,
        input  rd_valid, rd_addr,
        input  rsp_ready,
        input  Q1,
        output wr_ready, rd_ready,
        output rsp_valid, rsp_data,
        output CE0, A0, D0, WE0, WEM0, CE1, A1
    );

    modport master (
        output wr_valid, wr_addr, wr_data, wr_mask,
        output rd_valid, rd_addr,
        output rsp_ready,
        output Q1,
        input  wr_ready, rd_ready,
        input  rsp_valid, rsp_data,
        input  CE0, A0, D0, WE0, WEM0, CE1, A1
    );
endinterface

// File: rtl/slm_bank_access_ctrl.sv
// ----------------------------------------------------------------------------
// slm_bank_access_ctrl
//   Access controller in front of a single memory bank with one write port
//   (port 0) and one read port (port 1, one cycle read latency).
//
//   - Writes are never stalled and go straight to port 0 in the accept cycle.
//   - Reads go to port 1 in the accept cycle; the returned Q1 is captured
//     into a 2-entry response FIFO one cycle later, so responses appear two
//     cycles after accept, strictly in request order.
//   - A read is held off when a write to the same address is presented in
//     the same cycle, or when the FIFO could not absorb another response.
//
//   Ports:
//     CLK          clock, all state on rising edge
//     RST          asynchronous active-high reset
//     bus          slm_bank_access_ctrl_if.slave (handshakes + memory ports)
//     conflict_cnt (only with SLM_BANK_ACCESS_CTRL_STATS_EN) saturating
//                  count of cycles where a read was held off by an address
//                  conflict with a write
//
//   Configuration macro: SLM_BANK_ACCESS_CTRL_STATS_EN
// ----------------------------------------------------------------------------
module slm_bank_access_ctrl #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 64
) (
    input  logic                        CLK,
    input  logic                        RST,
`ifdef SLM_BANK_ACCESS_CTRL_STATS_EN
    output logic [15:0]                 conflict_cnt,
`endif
    slm_bank_access_ctrl_if.slave       bus
);

    // ------------------------------------------------------------------
    // Response FIFO state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              r_inflight;   // a read was issued last cycle, Q1 is live now

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_conflict;
    logic              w_credit;
    logic              w_rsp_valid;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;

    // ------------------------------------------------------------------
    // Accept logic
    // ------------------------------------------------------------------
    // Ready is gated by RST directly (not by a registered enable) so that
    // the very first cycle after release can already accept.
    assign w_wr_acc   = bus.wr_valid & ~RST;

    assign w_conflict = bus.wr_valid & bus.rd_valid & (bus.wr_addr == bus.rd_addr);

    assign w_rsp_valid = (r_count != 2'd0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;
    assign w_push      = r_inflight;

    // Entries already held plus the one on its way, less the one leaving
    // this cycle; a pop this cycle frees room for a read issued this cycle,
    // which is what allows one read per cycle with rsp_ready held high.
    assign w_occ    = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_credit = (w_occ < 3'd2);

    assign w_rd_acc = bus.rd_valid & ~RST & w_credit & ~w_conflict;

    assign bus.wr_ready  = ~RST;
    assign bus.rd_ready  = ~RST & w_credit & ~w_conflict;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Memory port drive: all controls and buses idle at zero unless a
    // request is accepted this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        bus.CE0  = 1'b0;
        bus.WE0  = 1'b0;
        bus.A0   = '0;
        bus.D0   = '0;
        bus.WEM0 = '0;
        bus.CE1  = 1'b0;
        bus.A1   = '0;
        if (w_wr_acc) begin
            bus.CE0  = 1'b1;
            bus.WE0  = 1'b1;
            bus.A0   = bus.wr_addr;
            bus.D0   = bus.wr_data;
            bus.WEM0 = bus.wr_mask;
        end
        if (w_rd_acc) begin
            bus.CE1 = 1'b1;
            bus.A1  = bus.rd_addr;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. Clearing r_inflight on reset discards a read that was
    // issued just before reset, so its Q1 is never captured.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_acc;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // NOTE: the FIFO data storage has no reset; its contents are only
    // observable once r_count marks them valid. A push always targets the
    // slot not currently at the head while an entry is waiting, so the
    // presented rsp_data never changes under a stalled consumer.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.Q1;
        end
    end

`ifdef SLM_BANK_ACCESS_CTRL_STATS_EN
    // ------------------------------------------------------------------
    // Conflict statistics
    // ------------------------------------------------------------------
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_conflict_cnt <= 16'd0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_slm_bank_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_slm_bank_access_ctrl
//   Drives slm_bank_access_ctrl through directed scenarios followed by a
//   randomized phase. The environment plays the memory bank (a sparse array
//   answering port 1 one cycle after CE1). Expected behaviour comes from a
//   transaction-level model: a golden memory updated on accepted writes and
//   a queue of outstanding reads tagged with their accept cycle.
// ----------------------------------------------------------------------------
module tb_slm_bank_access_ctrl;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 64;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct {
        data_t data;
        int    cyc;
    } rsp_t;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    slm_bank_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SLM_BANK_ACCESS_CTRL_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    slm_bank_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
`ifdef SLM_BANK_ACCESS_CTRL_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .bus          (bus)
    );

    // ------------------------------------------------------------------
    // Memory bank behaviour (environment)
    // ------------------------------------------------------------------
    data_t sram [addr_t];

    function automatic data_t sram_rd(input addr_t a);
        return sram.exists(a) ? sram[a] : '0;
    endfunction

    always @(posedge CLK) begin
        if (bus.CE1) bus.Q1 <= sram_rd(bus.A1);
        if (bus.CE0 && bus.WE0)
            sram[bus.A0] = (sram_rd(bus.A0) & ~bus.WEM0) | (bus.D0 & bus.WEM0);
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    data_t gold [addr_t];
    rsp_t  exp_q [$];
    int    cyc;
    int    exp_conf;
    int    n_checks;
    int    n_pass;
    int    n_rd_acc;     // read handshakes seen on the DUT
    int    n_pop;        // responses consumed
    data_t last_rsp;

    function automatic data_t gold_rd(input addr_t a);
        return gold.exists(a) ? gold[a] : '0;
    endfunction

    task automatic check(input string tag, input data_t got, input data_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Mid-cycle: compare everything the DUT presents against the model,
    // then advance the model by this cycle's transactions.
    task automatic sample();
        bit    conf, evalid, pop, credit, wacc, racc;
        data_t m;
        if (RST) begin
            exp_q.delete();
            exp_conf = 0;
        end
        conf   = bus.wr_valid && bus.rd_valid && (bus.wr_addr == bus.rd_addr);
        evalid = (exp_q.size() > 0) && (cyc - exp_q[0].cyc >= 2);
        pop    = evalid && bus.rsp_ready;
        credit = (exp_q.size() - int'(pop)) < 2;
        wacc   = !RST && bus.wr_valid;
        racc   = !RST && bus.rd_valid && credit && !conf;

        check("wr_ready", data_t'(bus.wr_ready), data_t'(!RST));
        check("ce0_we0_a0", data_t'({bus.CE0, bus.WE0, bus.A0}),
              wacc ? data_t'({2'b11, bus.wr_addr}) : '0);
        check("d0", bus.D0, wacc ? bus.wr_data : '0);
        check("wem0", bus.WEM0, wacc ? bus.wr_mask : '0);
        if (bus.rd_valid || RST)
            check("rd_ready", data_t'(bus.rd_ready), data_t'(racc));
        check("ce1_a1", data_t'({bus.CE1, bus.A1}),
              racc ? data_t'({1'b1, bus.rd_addr}) : '0);
        check("rsp_valid", data_t'(bus.rsp_valid), data_t'(evalid));
        if (evalid) check("rsp_data", bus.rsp_data, exp_q[0].data);
`ifdef SLM_BANK_ACCESS_CTRL_STATS_EN
        check("conflict_cnt", data_t'(conflict_cnt), data_t'(exp_conf));
`endif

        if (bus.rd_valid && bus.rd_ready) n_rd_acc++;
        if (pop) begin
            last_rsp = bus.rsp_data;
            n_pop++;
            void'(exp_q.pop_front());
        end
        if (racc) exp_q.push_back('{data: gold_rd(bus.rd_addr), cyc: cyc});
        if (wacc) begin
            m = bus.wr_mask;
            gold[bus.wr_addr] = (gold_rd(bus.wr_addr) & ~m) | (bus.wr_data & m);
        end
        if (!RST && conf && exp_conf < 16'hFFFF) exp_conf++;
    endtask

    task automatic tick();
        #4;
        sample();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit wv, input addr_t wa, input data_t wd, input data_t wm,
                         input bit rv, input addr_t ra, input bit rr);
        bus.wr_valid  = wv;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.wr_mask   = wm;
        bus.rd_valid  = rv;
        bus.rd_addr   = ra;
        bus.rsp_ready = rr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, '0, '0, '0, 0, '0, 1);
            tick();
        end
    endtask

    function automatic addr_t rand_addr();
        addr_t a;
        a     = addr_t'($urandom_range(0, 3));
        a[18] = 1'($urandom_range(0, 1));
        return a;
    endfunction

    function automatic data_t rand_mask();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return 64'h0000_0000_FFFF_FFFF;
            2:       return 64'hFFFF_FFFF_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int acc0;
        int pop0;
        cyc      = 0;
        exp_conf = 0;
        n_checks = 0;
        n_pass   = 0;
        n_rd_acc = 0;
        n_pop    = 0;
        last_rsp = '0;
        RST      = 1'b1;
        drive(1, 19'h5, 64'h1, '1, 1, 19'h6, 1);   // requests during reset must be ignored
        tick();
        tick();
        RST = 1'b0;

        // Single write then read of the same word
        drive(1, 19'h10, 64'hDEADBEEF_CAFEF00D, '1, 0, '0, 1);
        tick();
        drive(0, '0, '0, '0, 1, 19'h10, 1);
        tick();
        idle(2);
        check("req020_data", last_rsp, 64'hDEADBEEF_CAFEF00D);

        // Masked write over prior contents
        drive(1, 19'h20, {16{4'hA}}, '1, 0, '0, 1);
        tick();
        drive(1, 19'h20, {16{4'h1}}, 64'h0000_0000_FFFF_FFFF, 0, '0, 1);
        tick();
        drive(0, '0, '0, '0, 1, 19'h20, 1);
        tick();
        idle(2);
        check("req021_data", last_rsp, 64'hAAAAAAAA_11111111);

        // Same-address conflict: write wins, read follows a cycle later
        drive(1, 19'h30, 64'h0123_4567_89AB_CDEF, '1, 0, '0, 1);
        tick();
        drive(1, 19'h30, 64'h5555_6666_7777_8888, '1, 1, 19'h30, 1);
        tick();
        drive(0, '0, '0, '0, 1, 19'h30, 1);
        tick();
        idle(2);
        check("req022_data", last_rsp, 64'h5555_6666_7777_8888);
`ifdef SLM_BANK_ACCESS_CTRL_STATS_EN
        check("req022_cnt", data_t'(conflict_cnt), 64'd1);
`endif

        // Preload words 0..15
        for (int i = 0; i < 16; i++) begin
            drive(1, addr_t'(i), {$urandom, $urandom}, '1, 0, '0, 1);
            tick();
        end

        // Back-to-back reads with the consumer always ready
        acc0 = n_rd_acc;
        pop0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            drive(0, '0, '0, '0, 1, addr_t'(i), 1);
            tick();
        end
        check("req023_accepts", data_t'(n_rd_acc - acc0), 64'd8);
        idle(3);
        check("req023_responses", data_t'(n_pop - pop0), 64'd8);

        // Stalled consumer: only two reads fit
        acc0 = n_rd_acc;
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, '0, '0, 1, addr_t'(8 + i), 0);
            tick();
        end
        check("req024_accepts", data_t'(n_rd_acc - acc0), 64'd2);
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, '0, '0, 1, addr_t'(8 + i), 1);
            tick();
        end
        idle(3);

        // Reset in the middle of a stream with a read in flight
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, '0, '0, 1, addr_t'(i), 1);
            tick();
        end
        drive(0, '0, '0, '0, 0, '0, 1);
        RST = 1'b1;
        #1;
        check("req025_rsp_valid", data_t'(bus.rsp_valid), 64'd0);
        #3;
        sample();
        @(posedge CLK);
        #1;
        cyc++;
        RST = 1'b0;
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom}, rand_mask(),
                  ($urandom_range(0, 9) < 6), rand_addr(), ($urandom_range(0, 9) < 7));
            RST = ($urandom_range(0, 149) == 0);
            tick();
            RST = 1'b0;
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
